// File: rtl/lab_seq_pkg.sv
// Shared definitions for the truth-table sequencer: FSM state encoding and
// the default per-vector hold time.
package lab_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } seq_state_e;

    localparam int unsigned DEFAULT_HOLD_CYCLES = 4;

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter that times how long each vector is held on the CUT.
// expired is high on the last hold cycle and stays high once the count has
// run out, so a late exit (e.g. waiting for a step pulse) still sees it.
module hold_timer #(
    parameter int unsigned CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expired
);

    localparam int unsigned CW = $clog2(CYCLES + 1);

    logic [CW-1:0] cnt_q;

    // Reload on entry to APPLY, otherwise count down to zero and stop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= CW'(CYCLES);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign expired = (cnt_q <= CW'(1));

endmodule

// File: rtl/truth_table_sequencer.sv
// Self-test controller: walks every input vector of a combinational CUT,
// holds each for HOLD_CYCLES cycles, samples dut_y and compares it with the
// golden table EXPECT. Reports mismatch count and first failing vector.
// Optional macro TRUTH_TABLE_SINGLE_STEP_EN adds a step input; each vector
// then advances only on a step pulse after its hold time has elapsed.
module truth_table_sequencer
    import lab_seq_pkg::*;
#(
    parameter int unsigned         IN_W        = 4,
    parameter int unsigned         HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    parameter logic [2**IN_W-1:0]  EXPECT      = 16'hA5C3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
`ifdef TRUTH_TABLE_SINGLE_STEP_EN
    input  logic            step,
`endif
    input  logic            dut_y,
    output logic [IN_W-1:0] vec,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [IN_W:0]   err_count,
    output logic [IN_W-1:0] fail_vec,
    output logic            fail_valid
);

    localparam logic [IN_W-1:0] LAST_VEC = '1;
    localparam logic [IN_W-1:0] VEC_ONE  = IN_W'(1);
    localparam logic [IN_W:0]   ERR_ONE  = (IN_W + 1)'(1);

    seq_state_e      state_q, state_d;
    logic [IN_W-1:0] vec_q, vec_d;
    logic [IN_W:0]   err_q, err_d;
    logic [IN_W-1:0] fvec_q, fvec_d;
    logic            fvalid_q, fvalid_d;
    logic            busy_q, done_q, pass_q;
    logic            load;
    logic            expired;
    logic            step_ok;

`ifdef TRUTH_TABLE_SINGLE_STEP_EN
    assign step_ok = step;
`else
    assign step_ok = 1'b1;
`endif

    hold_timer #(
        .CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .expired (expired)
    );

    // Next-state, vector counter and compare/result update.
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        err_d    = err_q;
        fvec_d   = fvec_q;
        fvalid_d = fvalid_q;
        load     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = APPLY;
                    vec_d    = '0;
                    err_d    = '0;
                    fvec_d   = '0;
                    fvalid_d = 1'b0;
                    load     = 1'b1;
                end
            end
            APPLY: begin
                if (expired && step_ok) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (dut_y != EXPECT[vec_q]) begin
                    err_d = err_q + ERR_ONE;
                    if (!fvalid_q) begin
                        fvec_d   = vec_q;
                        fvalid_d = 1'b1;
                    end
                end
                if (vec_q == LAST_VEC) begin
                    // Hold the final vector; no wrap back to 0 within a run.
                    state_d = DONE;
                end else begin
                    vec_d   = vec_q + VEC_ONE;
                    state_d = APPLY;
                    load    = 1'b1;
                end
            end
            DONE: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, vector and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            vec_q    <= '0;
            err_q    <= '0;
            fvec_q   <= '0;
            fvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            err_q    <= err_d;
            fvec_q   <= fvec_d;
            fvalid_q <= fvalid_d;
        end
    end

    // Status outputs registered from the current state, so done/pass appear
    // once the last compare has settled into err_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            busy_q <= (state_q == APPLY) || (state_q == SAMPLE);
            done_q <= (state_q == DONE);
            if ((state_q == IDLE) && start) begin
                pass_q <= 1'b0;
            end else if (state_q == DONE) begin
                pass_q <= (err_q == '0);
            end
        end
    end

    assign vec        = vec_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_vec   = fvec_q;
    assign fail_valid = fvalid_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Self-checking bench for truth_table_sequencer with a modelled CUT.
// Build with TRUTH_TABLE_SINGLE_STEP_EN defined to exercise single-step mode.
module tb_truth_table_sequencer;

    localparam int          IN_W   = 4;
    localparam int          HOLD   = 4;
    localparam int          NVEC   = 16;
    localparam int          LAT    = NVEC * (HOLD + 1) + 1;
    localparam logic [15:0] GOLDEN = 16'hA5C3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            step = 1'b0;
    logic            dut_y;
    logic [IN_W-1:0] vec;
    logic            busy, done, pass, fail_valid;
    logic [IN_W:0]   err_count;
    logic [IN_W-1:0] fail_vec;

    // CUT model: 0 good, 1 stuck-at-0, 2 inverted, 3 arbitrary table.
    int          mode = 0;
    logic [15:0] cut_tab = 16'h0;

    int checks = 0;
    int passes = 0;

    truth_table_sequencer #(
        .IN_W        (IN_W),
        .HOLD_CYCLES (HOLD),
        .EXPECT      (GOLDEN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
`ifdef TRUTH_TABLE_SINGLE_STEP_EN
        .step       (step),
`endif
        .dut_y      (dut_y),
        .vec        (vec),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .fail_vec   (fail_vec),
        .fail_valid (fail_valid)
    );

    always #5 clk = ~clk;

    function automatic logic cut_out(input int m, input int k);
        case (m)
            0:       return GOLDEN[k];
            1:       return 1'b0;
            2:       return ~GOLDEN[k];
            default: return cut_tab[k];
        endcase
    endfunction

    assign dut_y = cut_out(mode, int'(vec));

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_vec"}, int'(vec), 0);
        check_eq({tag, "_busy"}, int'(busy), 0);
        check_eq({tag, "_done"}, int'(done), 0);
        check_eq({tag, "_pass"}, int'(pass), 0);
        check_eq({tag, "_err"}, int'(err_count), 0);
        check_eq({tag, "_fvec"}, int'(fail_vec), 0);
        check_eq({tag, "_fvalid"}, int'(fail_valid), 0);
    endtask

`ifndef TRUTH_TABLE_SINGLE_STEP_EN
    // pulse_len = 0 keeps start high for the whole run.
    task automatic run_and_check(input int cut_mode, input int pulse_len, input string name);
        int c;
        int exp_err;
        int exp_first;
        int exp_vec;
        mode      = cut_mode;
        exp_err   = 0;
        exp_first = 0;
        for (int k = NVEC - 1; k >= 0; k--) begin
            if (cut_out(cut_mode, k) != GOLDEN[k]) begin
                exp_err++;
                exp_first = k;
            end
        end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        c = 0;
        if (pulse_len == 1) start = 1'b0;
        while (!done && c < 3 * LAT) begin
            @(posedge clk);
            #1;
            c++;
            if (pulse_len > 0 && c >= pulse_len - 1) start = 1'b0;
            exp_vec = c / (HOLD + 1);
            if (exp_vec > NVEC - 1) exp_vec = NVEC - 1;
            check_eq({name, "_vec_walk"}, int'(vec), exp_vec);
            if (!done) check_eq({name, "_busy"}, int'(busy), int'(c >= 1 && c <= LAT - 1));
        end
        check_eq({name, "_latency"}, c, LAT);
        check_eq({name, "_err"}, int'(err_count), exp_err);
        check_eq({name, "_pass"}, int'(pass), int'(exp_err == 0));
        check_eq({name, "_fvalid"}, int'(fail_valid), int'(exp_err != 0));
        check_eq({name, "_fvec"}, int'(fail_vec), exp_first);
    endtask
`endif

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("idle");

`ifdef TRUTH_TABLE_SINGLE_STEP_EN
        begin
            int c;
            mode = 0;
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (100) @(posedge clk);
            #1;
            check_eq("step_none_vec", int'(vec), 0);
            check_eq("step_none_busy", int'(busy), 1);
            check_eq("step_none_done", int'(done), 0);
            for (int p = 0; p < NVEC; p++) begin
                step = 1'b1;
                @(posedge clk);
                #1;
                step = 1'b0;
                repeat (HOLD + 1) @(posedge clk);
                #1;
                if (p < NVEC - 1) check_eq("step_vec", int'(vec), p + 1);
            end
            c = 0;
            while (!done && c < 50) begin
                @(posedge clk);
                #1;
                c++;
            end
            check_eq("step_done", int'(done), 1);
            check_eq("step_pass", int'(pass), 1);
            check_eq("step_err", int'(err_count), 0);
        end
`else
        // Good CUT, one-cycle start pulse.
        run_and_check(0, 1, "good");
        repeat (3) @(posedge clk);
        // Stuck-at-0: mismatches on the 8 ones of the golden table.
        run_and_check(1, 1, "stuck0");
        repeat (3) @(posedge clk);
        // Inverted: every vector fails, err_count reaches 16 without wrap.
        run_and_check(2, 2, "invert");
        check_eq("invert_nowrap", int'(err_count), NVEC);
        repeat (3) @(posedge clk);

        // Asynchronous reset in the middle of a stuck-at-0 run.
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check_eq("midrun_err_nonzero", int'(err_count != 0), 1);
        #1;
        reset = 1'b1;
        #1;
        check_reset_vals("midrun_reset");
        @(negedge clk);
        reset = 1'b0;
        run_and_check(0, 1, "after_reset");
        repeat (3) @(posedge clk);

        // start held high: single run, then parked in DONE.
        run_and_check(1, 0, "held");
        repeat (20) @(posedge clk);
        #1;
        check_eq("held_done_stays", int'(done), 1);
        check_eq("held_vec_final", int'(vec), NVEC - 1);
        check_eq("held_no_rerun", int'(busy), 0);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("dropped_done", int'(done), 0);
        check_eq("dropped_err_kept", int'(err_count), 8);
        check_eq("dropped_fvalid_kept", int'(fail_valid), 1);
        check_eq("dropped_fvec_kept", int'(fail_vec), 0);
        run_and_check(0, 1, "rerun");
        repeat (3) @(posedge clk);

        // Random CUT tables with varying start pulse widths.
        for (int r = 0; r < 4; r++) begin
            cut_tab = 16'($urandom);
            run_and_check(3, 1 + int'($urandom_range(0, 2)), "random");
            repeat (3) @(posedge clk);
        end
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
